hv_result_packer: RTL and testbench

//  Read-out end of the bundling accumulators. Snapshots the sign bit of all DIM
//  per-dimension counters on a start pulse and packs them into DW-bit words.

---
 rtl/hv_result_packer.sv | 125 ++++++++++++
 tb/tb_hv_result_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : hv_result_packer
// Snapshots DIM counter sign bits on start and streams them as DW-bit words
// over valid/ready, pulsing a counter clear after the snapshot.
// Revision : 1.0
// ============================================================================
module hv_result_packer #(
    parameter int DIM = 1024,
    parameter int DW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [DIM-1:0]  i_sign_bits,
    output logic            o_ctr_clr,
    output logic [DW-1:0]   o_out_data,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic            o_out_last,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_overrun
);

    localparam int NW = DIM / DW;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] c_LAST_IDX = IW'(NW - 1);

    generate
        if (DW < 1 || (DIM % DW) != 0) begin : g_param_check
            $error("hv_result_packer: DIM must be a non-zero multiple of DW");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic [DIM-1:0]  r_snap;
    logic [DIM-1:0]  w_snap_nxt;
    logic            r_ctr_clr;
    logic            w_ctr_clr_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_overrun;
    logic            w_overrun_nxt;
    logic            w_sending;
    logic            w_at_last;
    logic [DW-1:0]   w_word;

    assign w_sending = (r_state == S_SEND);
    assign w_at_last = (r_idx == c_LAST_IDX);
    assign w_word    = r_snap[int'(r_idx) * DW +: DW];

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_snap_nxt    = r_snap;
        w_ctr_clr_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_overrun_nxt = r_overrun;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_snap_nxt    = i_sign_bits;
                    w_idx_nxt     = '0;
                    w_ctr_clr_nxt = 1'b1;
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                // A start here, including the last-word cycle, is dropped and flagged
                if (i_start) begin
                    w_overrun_nxt = 1'b1;
                end
                if (i_out_ready) begin
                    if (w_at_last) begin
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_snap    <= '0;
            r_ctr_clr <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_snap    <= w_snap_nxt;
            r_ctr_clr <= w_ctr_clr_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign o_out_valid = w_sending;
    assign o_busy      = w_sending;
    assign o_out_last  = w_sending & w_at_last;
    assign o_out_data  = w_sending ? w_word : '0;
    assign o_ctr_clr   = r_ctr_clr;
    assign o_done      = r_done;
    assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_hv_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hv_result_packer
// Scoreboard bench for hv_result_packer (two-word and single-word builds).
// Revision : 1.0
// ============================================================================
module tb_hv_result_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] sign_bits = '0;
    logic        ready = 1'b0;
    logic        ctr_clr;
    logic [31:0] data;
    logic        valid;
    logic        last;
    logic        busy;
    logic        done;
    logic        overrun;

    logic        s_start = 1'b0;
    logic [31:0] s_sign = '0;
    logic        s_ready = 1'b1;
    logic        s_clr;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_busy;
    logic        s_done;
    logic        s_ovr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] q_exp[$];

    always #5 clk = ~clk;

    hv_result_packer #(.DIM(64), .DW(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_sign_bits (sign_bits),
        .o_ctr_clr   (ctr_clr),
        .o_out_data  (data),
        .o_out_valid (valid),
        .i_out_ready (ready),
        .o_out_last  (last),
        .o_busy      (busy),
        .o_done      (done),
        .o_overrun   (overrun)
    );

    hv_result_packer #(.DIM(32), .DW(32)) u_dut_nw1 (
        .clk         (clk),
        .rst         (rst),
        .i_start     (s_start),
        .i_sign_bits (s_sign),
        .o_ctr_clr   (s_clr),
        .o_out_data  (s_data),
        .o_out_valid (s_valid),
        .i_out_ready (s_ready),
        .o_out_last  (s_last),
        .o_busy      (s_busy),
        .o_done      (s_done),
        .o_overrun   (s_ovr)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] v, input bit push);
        sign_bits = v;
        start     = 1'b1;
        if (push) begin
            q_exp.push_back({1'b0, v[31:0]});
            q_exp.push_back({1'b1, v[63:32]});
        end
        step();
        start = 1'b0;
    endtask

    // Transfers happen at the next posedge; inputs only change just after posedge
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (q_exp.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                logic [32:0] e;
                e = q_exp.pop_front();
                check("sb_data", 64'(data), 64'(e[31:0]));
                check("sb_last", 64'(last), 64'(e[32]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_clr", 64'(ctr_clr), 64'd0);
        check("rst_ovr", 64'(overrun), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // 1: back-to-back stream with ready high
        ready = 1'b1;
        do_start(64'hF0F0_0000_1234_5678, 1'b1);
        check("t1_valid", 64'(valid), 64'd1);
        check("t1_clr", 64'(ctr_clr), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_w0", 64'(data), 64'h1234_5678);
        check("t1_last0", 64'(last), 64'd0);
        step();
        check("t1_clr_off", 64'(ctr_clr), 64'd0);
        check("t1_w1", 64'(data), 64'hF0F0_0000);
        check("t1_last1", 64'(last), 64'd1);
        step();
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy_off", 64'(busy), 64'd0);
        check("t1_valid_off", 64'(valid), 64'd0);
        step();
        check("t1_done_pulse", 64'(done), 64'd0);

        // 2: backpressure holds word 0
        ready = 1'b0;
        do_start(64'hA5A5_C3C3_0F0F_9669, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 64'(valid), 64'd1);
            check("t2_hold_data", 64'(data), 64'h0F0F_9669);
            check("t2_hold_last", 64'(last), 64'd0);
            step();
        end
        ready = 1'b1;
        step();
        check("t2_w1", 64'(data), 64'hA5A5_C3C3);
        step();
        check("t2_done", 64'(done), 64'd1);

        // 3: start during SEND is ignored and flagged
        do_start(64'h1111_2222_3333_4444, 1'b1);
        sign_bits = 64'hDEAD_BEEF_CAFE_F00D;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t3_ovr", 64'(overrun), 64'd1);
        check("t3_no_clr", 64'(ctr_clr), 64'd0);
        check("t3_w1_old", 64'(data), 64'h1111_2222);
        step();
        check("t3_done", 64'(done), 64'd1);
        step();
        check("t3_ovr_sticky", 64'(overrun), 64'd1);
        check("t3_idle", 64'(valid), 64'd0);

        // 4: asynchronous reset while idx=1
        ready = 1'b0;
        do_start(64'h7777_6666_5555_4444, 1'b1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("t4_idx1", 64'(data), 64'h7777_6666);
        #2 rst = 1'b1;
        #1;
        check("t4_valid", 64'(valid), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_ovr", 64'(overrun), 64'd0);
        q_exp.delete();
        step();
        rst = 1'b0;
        check("t4_no_done", 64'(done), 64'd0);
        step();
        check("t4_no_done2", 64'(done), 64'd0);
        check("t4_no_clr", 64'(ctr_clr), 64'd0);
        ready = 1'b1;
        do_start(64'h0123_4567_89AB_CDEF, 1'b1);
        check("t4_new_w0", 64'(data), 64'h89AB_CDEF);
        check("t4_new_clr", 64'(ctr_clr), 64'd1);
        step();
        step();
        check("t4_done", 64'(done), 64'd1);

        // 5: start on last-word acceptance ignored; start in done cycle accepted
        do_start(64'h0000_0002_0000_0001, 1'b1);
        step();
        sign_bits = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1;
        step();
        check("t5_done", 64'(done), 64'd1);
        check("t5_ovr", 64'(overrun), 64'd1);
        check("t5_valid_off", 64'(valid), 64'd0);
        check("t5_no_clr", 64'(ctr_clr), 64'd0);
        do_start(64'hCAFE_0003_BEEF_0004, 1'b1);
        check("t5_valid", 64'(valid), 64'd1);
        check("t5_clr", 64'(ctr_clr), 64'd1);
        check("t5_w0", 64'(data), 64'hBEEF_0004);
        step();
        step();
        check("t5_done2", 64'(done), 64'd1);
        check("sb_empty", 64'(q_exp.size()), 64'd0);

        // 6: single-word build
        s_sign  = 32'h8000_0001;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        check("t6_valid", 64'(s_valid), 64'd1);
        check("t6_last", 64'(s_last), 64'd1);
        check("t6_data", 64'(s_data), 64'h8000_0001);
        check("t6_clr", 64'(s_clr), 64'd1);
        step();
        check("t6_done", 64'(s_done), 64'd1);
        check("t6_valid_off", 64'(s_valid), 64'd0);
        check("t6_busy_off", 64'(s_busy), 64'd0);
        step();
        check("t6_done_pulse", 64'(s_done), 64'd0);
        check("t6_ovr", 64'(s_ovr), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
